lap_sequencer: RTL and testbench
================================

// Module: lap_sequencer
// PURPOSE
// - Run-control sequencer for the 4-digit BCD stopwatch counter chain (10ms/100ms/1s/10s cnt10 cascade).
// - Takes debounced start/stop/lap pulses and the 100 Hz tick. Drives the chain's count-enable and clear.
// - Latches lap (split) snapshots and selects the live or frozen time toward the seg7dec stage.
// - Stops the count at 99.99 s instead of wrapping, and flags saturation with a blinking decimal point.
// PARAMETERS
// - BLINK_TICKS  25        ticks per blink half-period in FULL (25 x 10 ms = 2 Hz toggle)
// - MAX_BCD      16'h9999  terminal count; the chain never increments past this
// - LAP_MAX      9         lap counter saturation value
// PORTS
// - clk        in   1   system clock; single clock domain
// - rst        in   1   reset, asynchronous, active-high
// - start_b    in   1   debounced start, 1-clk pulse
// - stop_b     in   1   debounced stop, 1-clk pulse
// - lap_b      in   1   debounced lap, 1-clk pulse
// - tick       in   1   100 Hz enable, 1-clk pulse
// - time_bcd   in   16  live chain value {10s,1s,100ms,10ms}, 4 bits per digit
// - cnt_inc    out  1   increment strobe to the chain (combinational)
// - cnt_clr    out  1   synchronous clear to the chain, 1-clk pulse (registered)
// - disp_bcd   out  16  digits to display
// - disp_dp    out  4   decimal points, active-high; bit i = digit i
// - lap_num    out  4   laps taken since clear, 0..LAP_MAX
// - running    out  1   high in RUN or LAP
// BEHAVIOUR
// - Reset values: state=IDLE, cnt_clr=0, lap_bcd=0, lap_num=0, blink=0.
// - Reset outputs: running=0, disp_bcd=time_bcd, disp_dp=4'b0100.
// - States: IDLE, RUN, LAP, PAUSE, FULL. All transitions are registered, 1 clk after the input pulse.
// - Same-cycle button priority: stop_b > lap_b > start_b. Lower-priority pulses in that cycle are dropped.
// - IDLE: start -> RUN. stop and lap are ignored.
// - RUN: stop -> PAUSE.
// - RUN: lap -> LAP. Captures lap_bcd <= time_bcd and increments lap_num (saturates at LAP_MAX).
// - LAP: lap -> stays LAP. Re-captures lap_bcd and increments lap_num.
// - LAP: start -> RUN (display released). stop -> PAUSE.
// - PAUSE: start -> RUN. stop -> IDLE, with cnt_clr=1 for 1 clk and lap_num<=0, lap_bcd<=0.
// - FULL: stop -> IDLE, with the same clear actions. start and lap are ignored.
// - Saturation: in RUN or LAP with time_bcd==MAX_BCD, go to FULL next clk. This is checked before buttons, except stop.
// - cnt_inc = tick & (state==RUN | state==LAP) & (time_bcd != MAX_BCD). Zero latency.
// - A tick in the same cycle as stop_b is still counted (state is still RUN). Chain can never wrap 99.99 -> 00.00.
// - disp_bcd = lap_bcd in LAP; time_bcd in all other states.
// - disp_dp in IDLE/RUN/PAUSE: 4'b0100 (seconds point).
// - disp_dp in LAP: 4'b1100 (digit 3 point marks frozen lap).
// - disp_dp in FULL: {4{blink}}.
// - blink toggles every BLINK_TICKS ticks. Its tick counter is cleared on FULL entry and held at 0 outside FULL.
// - Reset mid-operation: immediate return to reset values. cnt_clr is not pulsed, since the chain has its own reset.
// - time_bcd is trusted BCD. Non-BCD digits are not checked.
// STRUCTURE
// - Shared package: state enum (IDLE,RUN,LAP,PAUSE,FULL), MAX_BCD default, DP_SEC=4'b0100, DP_LAP=4'b1100.
// - Sub-module blink_timer: tick-counted toggle with clear and enable, parameter BLINK_TICKS.
// - FSM, lap register and display mux stay in lap_sequencer.
// TESTING
// - Reset, then start_b, then 150 ticks -> cnt_inc pulses 150 times; running=1; time reaches 16'h0150.
// - RUN at 16'h0150, lap_b -> LAP; lap_num=1; disp_bcd=16'h0150 while time advances.
//   50 more ticks -> disp_bcd still 16'h0150. start_b -> disp_bcd follows time.
// - RUN, stop_b -> PAUSE; ticks give cnt_inc=0.
//   stop_b again -> IDLE, cnt_clr high exactly 1 clk, lap_num=0.
// - Chain preset to 16'h9998 in RUN, 2 ticks -> 1 cnt_inc, then FULL.
//   Further ticks give no cnt_inc. disp_dp toggles 0000/1111 every 25 ticks.
// - Same-cycle stop_b+lap_b+tick in RUN -> PAUSE, no lap capture, tick counted.
//   Assert rst in LAP -> IDLE, lap_num=0, disp_dp=4'b0100 immediately.

Source files
------------

// File: rtl/lap_sequencer_pkg.sv
// Shared types and constants for the stopwatch lap sequencer.
package lap_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE,
    S_FULL
  } state_t;

  localparam logic [15:0] MAX_BCD_DEF = 16'h9999;
  localparam logic [3:0]  LAP_MAX_DEF = 4'd9;
  localparam logic [3:0]  DP_SEC      = 4'b0100;
  localparam logic [3:0]  DP_LAP      = 4'b1100;

endpackage

// File: rtl/lap_sequencer_blink_timer.sv
// Tick-counted toggle used to blink the decimal points once saturated.
module blink_timer #(
  parameter int BLINK_TICKS = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_tick,
  output logic o_blink
);

  localparam int CW = $clog2(BLINK_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(BLINK_TICKS - 1);

  logic [CW-1:0] r_cnt;
  logic          r_blink;

  // Counter and phase sit at zero whenever the timer is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_blink <= 1'b0;
    end else if (i_clr || !i_en) begin
      r_cnt   <= '0;
      r_blink <= 1'b0;
    end else if (i_tick) begin
      if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_blink = r_blink;

endmodule

// File: rtl/lap_sequencer.sv
// Run-control, lap capture and display select for the BCD stopwatch chain.
module lap_sequencer
  import lap_sequencer_pkg::*;
#(
  parameter int          BLINK_TICKS = 25,
  parameter logic [15:0] MAX_BCD     = MAX_BCD_DEF,
  parameter logic [3:0]  LAP_MAX     = LAP_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_b,
  input  logic        stop_b,
  input  logic        lap_b,
  input  logic        tick,
  input  logic [15:0] time_bcd,
  output logic        cnt_inc,
  output logic        cnt_clr,
  output logic [15:0] disp_bcd,
  output logic [3:0]  disp_dp,
  output logic [3:0]  lap_num,
  output logic        running
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_lap_bcd;
  logic [3:0]  r_lap_num;
  logic        r_cnt_clr;
  logic        w_cap;
  logic        w_clr;
  logic        w_at_max;
  logic        w_live;
  logic        w_full_in;
  logic        w_blink;

  assign w_at_max = (time_bcd == MAX_BCD);
  assign w_live   = (r_state == S_RUN) || (r_state == S_LAP);

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_clr       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_b) w_state_nxt = S_RUN;
      end
      S_RUN, S_LAP: begin
        // Stop outranks saturation; saturation outranks lap/start.
        if (stop_b) begin
          w_state_nxt = S_PAUSE;
        end else if (w_at_max) begin
          w_state_nxt = S_FULL;
        end else if (lap_b) begin
          w_state_nxt = S_LAP;
          w_cap       = 1'b1;
        end else if (start_b && r_state == S_LAP) begin
          w_state_nxt = S_RUN;
        end
      end
      S_PAUSE: begin
        if (stop_b) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
        end else if (start_b) begin
          w_state_nxt = S_RUN;
        end
      end
      S_FULL: begin
        if (stop_b) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt_clr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt_clr <= w_clr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap_bcd <= '0;
      r_lap_num <= '0;
    end else if (w_clr) begin
      r_lap_bcd <= '0;
      r_lap_num <= '0;
    end else if (w_cap) begin
      r_lap_bcd <= time_bcd;
      if (r_lap_num != LAP_MAX) r_lap_num <= r_lap_num + 4'd1;
    end
  end

  assign w_full_in = (w_state_nxt == S_FULL) && (r_state != S_FULL);

  blink_timer #(
    .BLINK_TICKS(BLINK_TICKS)
  ) u_blink (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_full_in),
    .i_en   (r_state == S_FULL),
    .i_tick (tick),
    .o_blink(w_blink)
  );

  assign cnt_inc = tick && w_live && !w_at_max;
  assign cnt_clr = r_cnt_clr;
  assign running = w_live;
  assign lap_num = r_lap_num;

  always_comb begin
    disp_bcd = time_bcd;
    disp_dp  = DP_SEC;
    unique case (r_state)
      S_LAP: begin
        disp_bcd = r_lap_bcd;
        disp_dp  = DP_LAP;
      end
      S_FULL: disp_dp = {4{w_blink}};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lap_sequencer.sv
// Directed bench for lap_sequencer with a behavioural BCD counter chain.
module tb_lap_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_b = 1'b0;
  logic        stop_b = 1'b0;
  logic        lap_b = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] time_bcd;
  logic        cnt_inc;
  logic        cnt_clr;
  logic [15:0] disp_bcd;
  logic [3:0]  disp_dp;
  logic [3:0]  lap_num;
  logic        running;

  logic        ld = 1'b0;
  logic [15:0] ld_val = '0;
  int          n_inc = 0;
  int          n_chk = 0;
  int          n_bad = 0;
  int          base;

  always #5 clk = ~clk;

  lap_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .start_b (start_b),
    .stop_b  (stop_b),
    .lap_b   (lap_b),
    .tick    (tick),
    .time_bcd(time_bcd),
    .cnt_inc (cnt_inc),
    .cnt_clr (cnt_clr),
    .disp_bcd(disp_bcd),
    .disp_dp (disp_dp),
    .lap_num (lap_num),
    .running (running)
  );

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
        else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) time_bcd <= '0;
    else if (ld) time_bcd <= ld_val;
    else if (cnt_clr) time_bcd <= '0;
    else if (cnt_inc) time_bcd <= bcd_inc(time_bcd);
  end

  always @(negedge clk) if (cnt_inc) n_inc++;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic st, input logic sp, input logic lp,
                     input logic tk);
    start_b = st;
    stop_b  = sp;
    lap_b   = lp;
    tick    = tk;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    stop_b  = 1'b0;
    lap_b   = 1'b0;
    tick    = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_run", 16'(running), 16'd0);
    chk("rst_dp", 16'(disp_dp), 16'h4);
    chk("rst_lapn", 16'(lap_num), 16'd0);
    chk("rst_clr", 16'(cnt_clr), 16'd0);
    chk("rst_disp", disp_bcd, 16'h0000);
    rst = 1'b0;

    drv(0, 1, 1, 0);
    chk("idle_ign", 16'(running), 16'd0);
    drv(1, 0, 0, 0);
    chk("start_run", 16'(running), 16'd1);
    ticks(150);
    chk("inc150", 16'(n_inc), 16'd150);
    chk("time150", time_bcd, 16'h0150);

    drv(0, 0, 1, 0);
    chk("lap_n1", 16'(lap_num), 16'd1);
    chk("lap_disp", disp_bcd, 16'h0150);
    chk("lap_dp", 16'(disp_dp), 16'hC);
    ticks(50);
    chk("lap_time", time_bcd, 16'h0200);
    chk("lap_frozen", disp_bcd, 16'h0150);
    drv(1, 0, 0, 0);
    chk("rel_disp", disp_bcd, 16'h0200);
    chk("rel_dp", 16'(disp_dp), 16'h4);

    drv(0, 1, 0, 0);
    chk("pause_run", 16'(running), 16'd0);
    base = n_inc;
    ticks(5);
    chk("pause_inc", 16'(n_inc - base), 16'd0);
    chk("pause_time", time_bcd, 16'h0200);
    drv(0, 1, 0, 0);
    chk("clr_hi", 16'(cnt_clr), 16'd1);
    chk("clr_lapn", 16'(lap_num), 16'd0);
    drv(0, 0, 0, 0);
    chk("clr_lo", 16'(cnt_clr), 16'd0);
    chk("clr_time", time_bcd, 16'h0000);

    drv(1, 0, 0, 0);
    ld_val = 16'h9998;
    ld = 1'b1;
    drv(0, 0, 0, 0);
    ld = 1'b0;
    chk("preset", time_bcd, 16'h9998);
    base = n_inc;
    ticks(2);
    chk("sat_inc", 16'(n_inc - base), 16'd1);
    chk("sat_time", time_bcd, 16'h9999);
    chk("full_run", 16'(running), 16'd0);
    chk("full_dp0", 16'(disp_dp), 16'h0);
    ticks(24);
    chk("full_dp24", 16'(disp_dp), 16'h0);
    ticks(1);
    chk("full_dp25", 16'(disp_dp), 16'hF);
    ticks(25);
    chk("full_dp50", 16'(disp_dp), 16'h0);
    chk("full_noinc", 16'(n_inc - base), 16'd1);
    drv(1, 0, 1, 1);
    chk("full_ign", 16'(lap_num), 16'd0);
    chk("full_time", time_bcd, 16'h9999);
    drv(0, 1, 0, 0);
    chk("full_clr", 16'(cnt_clr), 16'd1);
    drv(0, 0, 0, 0);
    chk("full_t0", time_bcd, 16'h0000);

    drv(1, 0, 0, 0);
    ticks(3);
    base = n_inc;
    drv(0, 1, 1, 1);
    chk("same_inc", 16'(n_inc - base), 16'd1);
    chk("same_run", 16'(running), 16'd0);
    chk("same_lapn", 16'(lap_num), 16'd0);
    chk("same_disp", disp_bcd, 16'h0004);

    drv(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drv(0, 0, 1, 1);
    chk("lap_sat", 16'(lap_num), 16'd9);
    chk("lap_last", disp_bcd, 16'h0013);
    rst = 1'b1;
    #1;
    chk("mid_lapn", 16'(lap_num), 16'd0);
    chk("mid_dp", 16'(disp_dp), 16'h4);
    chk("mid_run", 16'(running), 16'd0);
    chk("mid_clr", 16'(cnt_clr), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
